// File: rtl/core_launch_ctrl.sv
// Launch sequencer for the Kyber core: holds it in reset for the rst_pulse duration,
// waits a settle interval, strobes start, then supervises the run with a watchdog.
module core_launch_ctrl #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_pulse,
    input  logic             core_done,
    output logic             core_rst,
    output logic             core_start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, HOLD, SETTLE, START, RUN, DONE, TMO} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_d;
    logic [CNT_W-1:0] cycle_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            settle_cnt  <= settle_cnt_d;
            cycle_count <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        settle_cnt_d  = settle_cnt;
        cycle_count_d = cycle_count;
        case (state)
            IDLE:   if (rst_pulse) state_d = HOLD;
            HOLD: begin
                if (!rst_pulse) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt + 1'b1;
                if (settle_cnt == SETTLE_LAST) state_d = START;
            end
            START:  state_d = RUN;
            RUN: begin
                // completion wins over the watchdog when both land on the same cycle
                if (core_done) begin
                    state_d = DONE;
                end else begin
                    cycle_count_d = cycle_count + 1'b1;
                    if (cycle_count == TMO_LAST) state_d = TMO;
                end
            end
            DONE, TMO: if (rst_pulse) state_d = HOLD;
            default: state_d = IDLE;
        endcase
        if (rst_pulse && (state == SETTLE || state == START || state == RUN)) state_d = HOLD;
        // clear on entry so the count reads zero as soon as HOLD is visible
        if (state_d == HOLD) cycle_count_d = '0;
    end

    assign core_rst   = (state == IDLE) || (state == HOLD) || (state == TMO);
    assign core_start = (state == START);
    assign busy       = (state == HOLD) || (state == SETTLE) || (state == START) || (state == RUN);
    assign done       = (state == DONE);
    assign timeout    = (state == TMO);

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Directed bench for core_launch_ctrl: two instances (default watchdog, and an 8-cycle
// watchdog) share stimulus; expectations go through a scoreboard queue.
module tb_core_launch_ctrl;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst, rst_pulse, core_done;
    logic a_core_rst, a_core_start, a_busy, a_done, a_timeout;
    logic b_core_rst, b_core_start, b_busy, b_done, b_timeout;
    logic [CNT_W-1:0] a_cycle_count, b_cycle_count;

    always #5 clk = ~clk;

    core_launch_ctrl #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(65535), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .rst_pulse(rst_pulse), .core_done(core_done),
        .core_rst(a_core_rst), .core_start(a_core_start), .busy(a_busy),
        .done(a_done), .timeout(a_timeout), .cycle_count(a_cycle_count)
    );

    core_launch_ctrl #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .rst_pulse(rst_pulse), .core_done(core_done),
        .core_rst(b_core_rst), .core_start(b_core_start), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .cycle_count(b_cycle_count)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            e.tag = "scoreboard_underflow";
            e.val = 'x;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    endtask

    // pulse of n cycles, then advance to the first RUN cycle (4 settle + start)
    task automatic launch(input int n);
        rst_pulse = 1'b1;
        repeat (n) tick();
        rst_pulse = 1'b0;
        repeat (6) tick();
    endtask

    int  hi, gap;
    bit  found;

    initial begin
        rst = 1'b1; rst_pulse = 1'b0; core_done = 1'b0;

        // reset
        push("rst_core_rst", 1); push("rst_busy", 0); push("rst_done", 0);
        push("rst_timeout", 0); push("rst_core_start", 0); push("rst_cycle_count", 0);
        tick(); tick();
        chk(a_core_rst); chk(a_busy); chk(a_done);
        chk(a_timeout); chk(a_core_start); chk(a_cycle_count);
        rst = 1'b0;
        tick();

        // nominal launch: 10-cycle pulse, done on 21st RUN cycle
        push("nom_core_rst_cycles", 10); push("nom_start_gap", 4);
        push("nom_start_width", 0); push("nom_run_busy", 1);
        push("nom_done", 1); push("nom_cycle_count", 20); push("nom_busy", 0);
        push("nom_core_rst_done", 0);
        hi = 0; gap = 0; found = 0;
        rst_pulse = 1'b1;
        repeat (10) begin tick(); if (a_core_rst) hi++; end
        rst_pulse = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick(); gap++;
            if (a_core_rst) hi++;
            if (a_core_start) found = 1;
        end
        chk(hi);
        chk(gap - 1);
        tick();
        chk(a_core_start);
        repeat (20) tick();
        chk(a_busy);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk(a_done); chk(a_cycle_count); chk(a_busy); chk(a_core_rst);

        // watchdog on the 8-cycle instance
        push("hold_clears_done", 0); push("hold_busy", 1);
        push("tmo_c8_busy", 1); push("tmo_c8_timeout", 0);
        push("tmo_timeout", 1); push("tmo_cycle_count", 8); push("tmo_core_rst", 1);
        push("tmo_busy", 0); push("tmo_core_start", 0);
        rst_pulse = 1'b1;
        tick();
        chk(a_done); chk(b_busy);
        rst_pulse = 1'b0;
        repeat (6) tick();
        repeat (7) tick();
        chk(b_busy); chk(b_timeout);
        tick();
        chk(b_timeout); chk(b_cycle_count); chk(b_core_rst); chk(b_busy); chk(b_core_start);

        // done on the same cycle the watchdog would fire
        push("col_done", 1); push("col_timeout", 0); push("col_cycle_count", 7);
        launch(2);
        repeat (7) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk(b_done); chk(b_timeout); chk(b_cycle_count);

        // abort in 3rd RUN cycle, done glitch in SETTLE, relaunch completes
        push("abort_core_rst", 1); push("abort_cycle_count", 0); push("abort_busy", 1);
        push("glitch_done", 0); push("glitch_busy", 1);
        push("relaunch_start", 1); push("relaunch_done", 1); push("relaunch_cycle_count", 4);
        launch(2);
        repeat (2) tick();
        rst_pulse = 1'b1;
        tick();
        chk(a_core_rst); chk(a_cycle_count); chk(a_busy);
        tick();
        rst_pulse = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk(a_done); chk(a_busy);
        repeat (3) tick();
        chk(a_core_start);
        tick();
        repeat (4) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk(a_done); chk(a_cycle_count);

        // synchronous reset mid-run with core_done high
        push("srst_core_rst", 1); push("srst_busy", 0); push("srst_done", 0);
        push("srst_cycle_count", 0); push("srst_timeout", 0);
        push("post_srst_done", 0); push("post_srst_busy", 0);
        launch(1);
        repeat (2) tick();
        rst = 1'b1; core_done = 1'b1;
        tick();
        chk(a_core_rst); chk(a_busy); chk(a_done); chk(a_cycle_count); chk(a_timeout);
        rst = 1'b0; core_done = 1'b0;
        tick();
        chk(a_done); chk(a_busy);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/core_launch_ctrl.md
# core_launch_ctrl

Launch sequencer directly downstream of the `fsm_rst` edge-to-pulse stage. It consumes the fixed-length `rst_pulse` and holds the Kyber arithmetic core in reset for the pulse's duration. After release it waits a settle interval, issues a one-cycle start strobe, then supervises the run until `core_done` or a watchdog timeout. It exposes sticky status and a run-length counter to the register file.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles between reset release and start strobe; legal range ≥1.
- `TIMEOUT_CYCLES`, 65535: maximum RUN cycles before timeout; legal range ≥1, must fit in `CNT_W`.
- `CNT_W`, 16: width of counters and of `cycle_count`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `rst_pulse`, input, 1: launch request from `fsm_rst`; level-sensitive, may stay high for many cycles.
- `core_done`, input, 1: core completion flag; sampled only in RUN.
- `core_rst`, output, 1: reset to the core, active-high.
- `core_start`, output, 1: one-cycle start strobe to the core.
- `busy`, output, 1: high while a launch is in progress.
- `done`, output, 1: sticky; set when the run completes.
- `timeout`, output, 1: sticky; set when the watchdog fires.
- `cycle_count`, output, CNT_W: number of RUN cycles before `core_done` was seen.

## Operation
- Moore FSM. States: IDLE, HOLD, SETTLE, START, RUN, DONE, TMO. All outputs are registered or decoded from the state register; no input-to-output combinational path.
- Reset (`rst`=1 at an edge): state=IDLE, `core_rst`=1, `core_start`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0, internal settle counter=0. `rst` overrides every other input.
- IDLE: `core_rst`=1. Go to HOLD when `rst_pulse`=1.
- HOLD: `core_rst`=1, `busy`=1, `done` and `timeout` cleared, `cycle_count` cleared. Stay while `rst_pulse`=1. On `rst_pulse`=0, clear the settle counter and go to SETTLE.
- SETTLE: `core_rst`=0, `busy`=1. The settle counter increments each cycle. When the counter equals `SETTLE_CYCLES`-1, go to START.
- START: `core_start`=1 for exactly one cycle, `busy`=1. Then go to RUN.
- RUN: `busy`=1.
  - If `core_done`=1: go to DONE and freeze `cycle_count`.
  - Otherwise increment `cycle_count`. If the pre-increment value equals `TIMEOUT_CYCLES`-1, go to TMO.
  - `core_done` takes priority over timeout in the same cycle.
- DONE: `done`=1, `busy`=0, `core_rst`=0. Stay until `rst_pulse`=1, then go to HOLD.
- TMO: `timeout`=1, `busy`=0, `core_rst`=1 (the core is re-held in reset). Stay until `rst_pulse`=1, then go to HOLD.
- `rst_pulse`=1 in SETTLE, START or RUN aborts the launch and goes to HOLD. No `core_start` is issued on an abort edge.
- `core_done` is ignored in every state except RUN.
- `cycle_count` saturates by construction: the timeout fires before it can wrap.

## Timing
- `rst_pulse` first sampled high at edge k: HOLD from k, `core_rst`=1 and `busy`=1 visible after edge k.
- `rst_pulse` sampled low at edge m (pulse of N cycles): SETTLE from m, `core_rst` falls after m.
- START occupies the cycle after edge m+`SETTLE_CYCLES`. `core_start` is high for exactly one cycle, `SETTLE_CYCLES` cycles after `core_rst` deasserts.
- RUN begins the next cycle. If `core_done` is first sampled high in the j-th RUN cycle (j from 1), then `cycle_count`=j-1 and `done`=1 from the following cycle.
- Timeout: with `core_done` never asserted, TMO is entered after exactly `TIMEOUT_CYCLES` RUN cycles, with `cycle_count`=`TIMEOUT_CYCLES`.
- `rst` asserted mid-RUN: the next cycle shows reset values, including `core_rst`=1 and `busy`=0.

## Test plan
- Reset: hold `rst` for 2 cycles → `core_rst`=1, `busy`=`done`=`timeout`=`core_start`=0, `cycle_count`=0.
- Nominal launch (SETTLE_CYCLES=4): 10-cycle `rst_pulse`, then `core_done` high on the 21st RUN cycle →
  - `core_rst` high for 10 cycles;
  - `core_start` high once, 4 cycles after `core_rst` falls;
  - `done`=1, `cycle_count`=20, `busy`=0.
- Timeout (TIMEOUT_CYCLES=8): launch with `core_done` held at 0 → TMO after 8 RUN cycles, `timeout`=1, `cycle_count`=8, `core_rst`=1.
- Done/timeout collision (TIMEOUT_CYCLES=8): `core_done` high on RUN cycle 8 → DONE, `done`=1, `timeout`=0, `cycle_count`=7.
- Abort and relaunch: `rst_pulse` high during the 3rd RUN cycle → HOLD, `core_rst`=1, `cycle_count`=0. After the pulse ends, a full new launch completes normally. Also check that a 1-cycle `core_done` glitch during SETTLE is ignored.
- Sync reset mid-run: `rst`=1 during RUN with `core_done`=1 → reset values next cycle, `done` stays 0.
